// File: rtl/md_unit_iter_if.sv
// rtl/md_unit_iter_if.sv - issue/result bundle between the E stage and the multiply/divide unit
interface md_unit_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             req;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, req, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, req, output busy, done, hi, lo);
endinterface

// File: rtl/md_unit_iter.sv
// rtl/md_unit_iter.sv - iterative shift-add multiply / restoring divide unit owning HI/LO
module md_unit_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 8
) (
    input logic          clk,
    input logic          rst,
    md_unit_iter_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [2:0] OP_MULT = 3'd0;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_DIVU = 3'd3;
    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;
    localparam logic [2:0] OP_MADD = 3'd6;
    localparam logic [2:0] OP_MSUB = 3'd7;

    logic [1:0]         state;
    logic [2:0]         op_r;
    logic [CW-1:0]      cnt;
    logic               neg_q, neg_r;
    logic [WIDTH-1:0]   a_r, mb, sh, rem;
    logic [2*WIDTH-1:0] acc, mcand;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               done_r;

    logic               issue, signed_op;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] pp, prod, res;
    logic [WIDTH:0]     shifted, trial;

    assign issue     = bus.start && !bus.req && (state == S_IDLE);
    assign signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV) ||
                       (bus.op == OP_MADD) || (bus.op == OP_MSUB);
    assign a_mag     = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag     = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // One multiplier digit per cycle: sum of MUL_BITS shifted copies of the multiplicand.
    always_comb begin
        pp = '0;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (sh[i]) pp = pp + (mcand << i);
        end
    end

    // trial[WIDTH] set means the subtraction went negative and the old remainder is kept.
    assign shifted = {rem, sh[WIDTH-1]};
    assign trial   = shifted - {1'b0, mb};
    assign prod    = neg_q ? -acc : acc;

    // Signed magnitudes make most-negative / -1 fall out as quotient 2^(WIDTH-1), remainder 0.
    always_comb begin
        res = prod;
        if (op_r == OP_DIV || op_r == OP_DIVU) begin
            if (mb == '0) res = {a_r, {WIDTH{1'b1}}};
            else          res = {(neg_r ? -rem : rem), (neg_q ? -sh : sh)};
        end else if (op_r == OP_MADD) begin
            res = {hi_r, lo_r} + prod;
        end else if (op_r == OP_MSUB) begin
            res = {hi_r, lo_r} - prod;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            op_r   <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            a_r    <= '0;
            mb     <= '0;
            sh     <= '0;
            rem    <= '0;
            acc    <= '0;
            mcand  <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        op_r  <= bus.op;
                        neg_q <= signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_r <= signed_op && bus.a[WIDTH-1];
                        a_r   <= bus.a;
                        if (bus.op == OP_MTHI) begin
                            hi_r <= bus.a;
                        end else if (bus.op == OP_MTLO) begin
                            lo_r <= bus.a;
                        end else if (bus.op == OP_DIV || bus.op == OP_DIVU) begin
                            state <= S_DIV;
                            cnt   <= CW'(WIDTH);
                            sh    <= a_mag;
                            mb    <= b_mag;
                            rem   <= '0;
                        end else begin
                            state <= S_MUL;
                            cnt   <= CW'(WIDTH / MUL_BITS);
                            acc   <= '0;
                            mcand <= {{WIDTH{1'b0}}, a_mag};
                            sh    <= b_mag;
                        end
                    end
                end
                S_MUL: begin
                    acc   <= acc + pp;
                    mcand <= mcand << MUL_BITS;
                    sh    <= sh >> MUL_BITS;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= S_FIX;
                end
                S_DIV: begin
                    if (trial[WIDTH]) begin
                        rem <= shifted[WIDTH-1:0];
                        sh  <= {sh[WIDTH-2:0], 1'b0};
                    end else begin
                        rem <= trial[WIDTH-1:0];
                        sh  <= {sh[WIDTH-2:0], 1'b1};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= S_FIX;
                end
                default: begin
                    {hi_r, lo_r} <= res;
                    done_r       <= 1'b1;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = (state != S_IDLE);
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule

// File: tb/tb_md_unit_iter.sv
// tb/tb_md_unit_iter.sv - scoreboard bench for md_unit_iter with a reference arithmetic model
module tb_md_unit_iter;
    logic clk = 1'b0;
    logic rst = 1'b0;

    md_unit_iter_if #(.WIDTH(32)) bus ();

    md_unit_iter #(.WIDTH(32), .MUL_BITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          nchk = 0;
    int          nfail = 0;
    int          run = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definition of each op.
    task automatic model_push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] acc, sp, up;
        int          sa, sb;
        exp_t        e;
        acc = {m_hi, m_lo};
        sp  = 64'(longint'($signed(a)) * longint'($signed(b)));
        up  = {32'b0, a} * {32'b0, b};
        sa  = $signed(a);
        sb  = $signed(b);
        case (op)
            3'd0: acc = sp;
            3'd1: acc = up;
            3'd6: acc = acc + sp;
            3'd7: acc = acc - sp;
            3'd2: begin
                if (b == 0) acc = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) acc = {32'h0, 32'h80000000};
                else acc = {32'(sa % sb), 32'(sa / sb)};
            end
            3'd3: begin
                if (b == 0) acc = {a, 32'hFFFFFFFF};
                else acc = {a % b, a / b};
            end
            3'd4: acc[63:32] = a;
            default: acc[31:0] = a;
        endcase
        m_hi = acc[63:32];
        m_lo = acc[31:0];
        if (op != 3'd4 && op != 3'd5) begin
            e.hi = m_hi;
            e.lo = m_lo;
            e.cycles = (op == 3'd2 || op == 3'd3) ? 33 : 5;
            sbq.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            run = 0;
        end else begin
            if (bus.done) begin
                if (sbq.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("result_hi", 64'(bus.hi), 64'(e.hi));
                    check("result_lo", 64'(bus.lo), 64'(e.lo));
                    check("busy_cycles", 64'(run), 64'(e.cycles));
                end
                run = 0;
            end
            if (bus.busy) run++;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) check("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        wait_idle();
        bus.start = 1'b1;
        bus.req   = 1'b0;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        model_push(op, a, b);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        if (op == 3'd4) check("mthi", 64'(bus.hi), 64'(m_hi));
        if (op == 3'd5) check("mtlo", 64'(bus.lo), 64'(m_lo));
        if (op == 3'd4 || op == 3'd5) check("mt_no_busy", 64'(bus.busy), 64'd0);
    endtask

    task automatic check_hilo(input string name, input logic [31:0] h, input logic [31:0] l);
        wait_idle();
        check(name, {bus.hi, bus.lo}, {h, l});
    endtask

    function automatic logic [31:0] corner(input int sel);
        case (sel)
            0: return 32'h80000000;
            1: return 32'hFFFFFFFF;
            2: return 32'h0;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        bus.req   = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        issue(3'd0, 32'hFFFFFFFD, 32'd7);
        check_hilo("t1_mult", 32'hFFFFFFFF, 32'hFFFFFFEB);
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check_hilo("t2_multu", 32'hFFFFFFFE, 32'h00000001);
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        check_hilo("t3_div", 32'hFFFFFFFF, 32'hFFFFFFFD);
        issue(3'd3, 32'h12345678, 32'd0);
        check_hilo("t4_divu_zero", 32'h12345678, 32'hFFFFFFFF);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        check_hilo("t5_div_ovf", 32'h0, 32'h80000000);
        issue(3'd4, 32'd1, 32'd0);
        issue(3'd5, 32'd5, 32'd0);
        issue(3'd6, 32'd2, 32'd3);
        check_hilo("t6_madd", 32'd1, 32'h0000000B);
        issue(3'd4, 32'd0, 32'd0);
        issue(3'd5, 32'd0, 32'd0);
        issue(3'd7, 32'd1, 32'd1);
        check_hilo("t7_msub", 32'hFFFFFFFF, 32'hFFFFFFFF);

        // req blocks issue of both a long op and an MTLO
        bus.start = 1'b1; bus.req = 1'b1; bus.op = 3'd0; bus.a = 32'd5; bus.b = 32'd5;
        @(negedge clk);
        check("t8_req_busy", 64'(bus.busy), 64'd0);
        bus.op = 3'd5; bus.a = 32'h00C0FFEE;
        @(negedge clk);
        check("t8_req_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
        bus.start = 1'b0; bus.req = 1'b0;

        // starts while busy are dropped, MTHI included
        issue(3'd0, 32'd100, 32'd200);
        bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd9; bus.b = 32'd3;
        @(negedge clk);
        bus.op = 3'd4; bus.a = 32'hDEADBEEF;
        @(negedge clk);
        bus.start = 1'b0;
        check_hilo("t9_busy_ignore", 32'd0, 32'd20000);
        repeat (4) @(negedge clk);
        check("t9_no_extra", 64'(sbq.size()), 64'd0);

        // reset in the middle of a divide
        issue(3'd2, 32'hFFFFFC18, 32'd3);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        check("t10_rst_busy", 64'(bus.busy), 64'd0);
        check("t10_rst_hilo", {bus.hi, bus.lo}, 64'd0);
        sbq.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("t10_after_busy", 64'(bus.busy), 64'd0);
        check("t10_after_hilo", {bus.hi, bus.lo}, 64'd0);

        for (int i = 0; i < 60; i++) begin
            issue(3'($urandom_range(0, 7)), corner($urandom_range(0, 9)), corner($urandom_range(0, 9)));
        end
        wait_idle();
        repeat (3) @(negedge clk);
        check("final_queue_empty", 64'(sbq.size()), 64'd0);
        check("final_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
